// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer (main + skid), valid/ready flow control and flush.
// Latency: 1 cycle from accept to o_valid; o_ready is registered and drops only while both entries are full.
// Backpressure: with i_ready=0 one extra entry is absorbed into the skid slot, then o_ready=0 until a slot drains.
//
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-low reset (0 = reset)
//   i_valid/o_ready  upstream handshake (o_ready is a flop)
//   i_ctrl, i_data   upstream control bundle and NUM_LANES data lanes (lane k = [k*DATA_W +: DATA_W])
//   i_flush          discards every held entry and the incoming one
//   o_valid/i_ready  downstream handshake
//   o_ctrl, o_data   head entry; o_ctrl forced to zero while o_valid=0 (bubble)
//   o_stall_cnt      saturating count of cycles with o_valid=1 and i_ready=0
//   o_flush_cnt      saturating count of flushes that discarded at least one valid entry
// Build option: define PIPE_REG_STATS_EN to include the statistics counters; otherwise both
// counter outputs are tied to zero and no counter logic is built.

module pipe_stage_skid_reg #(
   parameter int CTRL_W    = 8,
   parameter int DATA_W    = 32,
   parameter int NUM_LANES = 4,
   parameter int CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [CTRL_W-1:0]           i_ctrl,
   input  logic [NUM_LANES*DATA_W-1:0] i_data,
   input  logic                        i_flush,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [CTRL_W-1:0]           o_ctrl,
   output logic [NUM_LANES*DATA_W-1:0] o_data,
   output logic [CNT_W-1:0]            o_stall_cnt,
   output logic [CNT_W-1:0]            o_flush_cnt
);

   localparam int DW = NUM_LANES * DATA_W;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_MAIN  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              ready_q, ready_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DW-1:0]     main_data_q, main_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DW-1:0]     skid_data_q, skid_data_d;

   logic out_vld;
   logic accept;
   logic emit;

   // The main entry always holds the head of the queue, so "valid" is simply "not empty".
   assign out_vld = (state_q != ST_EMPTY);
   assign accept  = i_valid & ready_q;
   assign emit    = out_vld & i_ready;

   // ------------------------------------------------------------------
   // Next-state and datapath selection
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_ctrl_d = i_ctrl;
               main_data_d = i_data;
               state_d     = ST_MAIN;
            end
         end
         ST_MAIN: begin
            if (accept && emit) begin
               // Head leaves while the new entry takes its place.
               main_ctrl_d = i_ctrl;
               main_data_d = i_data;
            end else if (accept) begin
               // Head is stuck; park the new entry behind it.
               skid_ctrl_d = i_ctrl;
               skid_data_d = i_data;
               state_d     = ST_SKID;
            end else if (emit) begin
               state_d = ST_EMPTY;
            end
         end
         ST_SKID: begin
            // o_ready is low in this state, so no accept can occur here.
            if (emit) begin
               main_ctrl_d = skid_ctrl_q;
               main_data_d = skid_data_q;
               skid_ctrl_d = '0;
               skid_data_d = '0;
               state_d     = ST_MAIN;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase

      // Flush overrides everything: held entries and any entry accepted this
      // cycle are discarded. A head emitted this cycle was already delivered.
      if (i_flush) begin
         state_d     = ST_EMPTY;
         skid_ctrl_d = '0;
         skid_data_d = '0;
      end

      // Registered ready: we can take a new entry next cycle unless both slots are full.
      ready_d = (state_d != ST_SKID);
   end

   // ------------------------------------------------------------------
   // State and storage registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_EMPTY;
         ready_q     <= 1'b0;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign o_valid = out_vld;
   assign o_ready = ready_q;
   // Bubbles carry an all-zero control bundle so no write enable can leak downstream.
   assign o_ctrl  = out_vld ? main_ctrl_q : '0;
   assign o_data  = main_data_q;

`ifdef PIPE_REG_STATS_EN
   // ------------------------------------------------------------------
   // Statistics counters (saturating, cleared by reset only)
   // ------------------------------------------------------------------
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             flush_kill;

   always_comb begin
      // A flush only counts if it actually discarded something: an entry accepted
      // this cycle, the parked skid entry, or a head that was not emitted.
      flush_kill = i_flush & (accept |
                              (state_q == ST_SKID) |
                              ((state_q == ST_MAIN) & ~emit));

      stall_cnt_d = stall_cnt_q;
      if (out_vld && !i_ready && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end

      flush_cnt_d = flush_cnt_q;
      if (flush_kill && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

endmodule
